ls08_bist_ctrl: RTL and testbench

- Built-in self-test sequencer for one 74LS08 quad 2-input AND model.
- On a `start` pulse it drives a fixed 18-vector stimulus set onto the gate inputs and waits a programmable settle time per vector. It then compares `y1..y4` against the expected AND results and reports pass/fail, the failure count and the first failing vector.
- It sits beside the `ls08_quad_and` instance on a board-level model and is the hardware equivalent of the gate's exhaustive truth-table check.

---
 rtl/ls08_bist_pkg.sv | 39 +++
 rtl/ls08_bist_vector_rom.sv | 18 +
 rtl/ls08_bist_ctrl.sv | 124 ++++++++++++
 tb/tb_ls08_bist_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ls08_bist_pkg.sv
// Shared definitions for the 74LS08 BIST sequencer: vector count, state
// encodings and the fixed stimulus/expected-response table.
package ls08_bist_pkg;

    localparam int         NUM_VECTORS = 18;
    localparam logic [4:0] NO_FAIL     = 5'd31;
    localparam logic [4:0] LAST_VEC    = 5'(NUM_VECTORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } bist_state_t;

    typedef struct packed {
        logic [7:0] ab;     // {a1,b1,a2,b2,a3,b3,a4,b4}
        logic [3:0] exp_y;  // {y1,y2,y3,y4}
    } bist_vec_t;

    // Vectors 0..15 walk one gate at a time through its four input pairs;
    // 16 drives everything high, 17 everything low.
    function automatic bist_vec_t ls08_vec(input logic [4:0] idx);
        bist_vec_t  v;
        logic [1:0] g;
        v.ab    = '0;
        v.exp_y = '0;
        g       = idx[3:2];
        if (idx < 5'd16) begin
            v.ab    = {6'b0, idx[1:0]} << (3'd6 - {g, 1'b0});
            v.exp_y = (idx[1:0] == 2'b11) ? (4'b1000 >> g) : 4'b0000;
        end else if (idx == 5'd16) begin
            v.ab    = 8'hFF;
            v.exp_y = 4'hF;
        end
        return v;
    endfunction

endpackage

// File: rtl/ls08_bist_vector_rom.sv
// Combinational lookup of one BIST vector: stimulus and expected gate outputs.
module ls08_bist_vector_rom
    import ls08_bist_pkg::*;
(
    input  logic [4:0] idx,
    output logic [7:0] ab,
    output logic [3:0] exp_y
);

    bist_vec_t v;

    always_comb begin
        v     = ls08_vec(idx);
        ab    = v.ab;
        exp_y = v.exp_y;
    end

endmodule

// File: rtl/ls08_bist_ctrl.sv
// BIST sequencer for a 74LS08 model: applies 18 vectors, waits a settle time,
// checks y and accumulates fail count / first failing index.
module ls08_bist_ctrl
    import ls08_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] y,
    output logic [7:0] ab,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] fail_count,
    output logic [4:0] first_fail,
    output logic [4:0] vec_idx,
    output logic [1:0] state_dbg
);

    localparam int               CNT_W    = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES);

    // Handshake: start is a level sampled only in IDLE; abort is honoured only
    // while a test is running; done is a single-cycle pulse, busy a level.
    bist_state_t      state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [4:0]       nxt_idx;
    logic [7:0]       nxt_ab, cur_ab;
    logic [3:0]       nxt_exp, cur_exp;
    logic             mismatch, aborting;

    // Two lookups: expected response of the vector under check, and the
    // stimulus of the vector to load next (vector 0 when starting from IDLE).
    assign nxt_idx = (state == ST_CHECK) ? vec_idx + 5'd1 : 5'd0;

    ls08_bist_vector_rom u_rom_cur (.idx(vec_idx), .ab(cur_ab), .exp_y(cur_exp));
    ls08_bist_vector_rom u_rom_nxt (.idx(nxt_idx), .ab(nxt_ab), .exp_y(nxt_exp));

    // Case inequality so an undriven or X gate output is never a match.
    assign mismatch  = (y !== cur_exp);
    assign aborting  = abort && ((state == ST_SETTLE) || (state == ST_CHECK));
    assign state_dbg = state;

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:   if (start) state_n = ST_SETTLE;
            ST_SETTLE: begin
                if (aborting)        state_n = ST_IDLE;
                else if (cnt == '0)  state_n = ST_CHECK;
            end
            ST_CHECK: begin
                if (aborting)                 state_n = ST_IDLE;
                else if (vec_idx == LAST_VEC) state_n = ST_DONE;
                else                          state_n = ST_SETTLE;
            end
            ST_DONE:   state_n = ST_IDLE;
            default:   state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            ab         <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_count <= '0;
            first_fail <= NO_FAIL;
            vec_idx    <= '0;
            cnt        <= '0;
        end else begin
            state <= state_n;
            busy  <= (state_n != ST_IDLE);
            done  <= (state_n == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        ab         <= nxt_ab;
                        vec_idx    <= '0;
                        cnt        <= CNT_INIT;
                        fail_count <= '0;
                        first_fail <= NO_FAIL;
                        pass       <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (aborting) begin
                        ab   <= '0;
                        pass <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (aborting) begin
                        ab   <= '0;
                        pass <= 1'b0;
                    end else begin
                        if (mismatch) begin
                            fail_count <= fail_count + 5'd1;
                            if (first_fail == NO_FAIL) first_fail <= vec_idx;
                        end
                        if (vec_idx != LAST_VEC) begin
                            vec_idx <= vec_idx + 5'd1;
                            ab      <= nxt_ab;
                            cnt     <= CNT_INIT;
                        end
                    end
                end
                ST_DONE: begin
                    pass <= (fail_count == '0);
                    ab   <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ls08_bist_ctrl.sv
// Bench for ls08_bist_ctrl: a behavioural 74LS08 with stuck-at faults feeds y;
// fixed cases plus random fault masks checked against a reference model.
module tb_ls08_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Instance a: default settle; instance b: SETTLE_CYCLES = 0
    logic       start_a, abort_a, busy_a, done_a, pass_a;
    logic [3:0] y_a, s0_a, s1_a;
    logic [7:0] ab_a;
    logic [4:0] fc_a, ff_a, vi_a;
    logic [1:0] st_a;

    logic       start_b, abort_b, busy_b, done_b, pass_b, x_on3_b;
    logic [3:0] y_b;
    logic [7:0] ab_b;
    logic [4:0] fc_b, ff_b, vi_b;
    logic [1:0] st_b;

    assign y_a = ({ab_a[7] & ab_a[6], ab_a[5] & ab_a[4], ab_a[3] & ab_a[2], ab_a[1] & ab_a[0]}
                  & ~s0_a) | s1_a;
    assign y_b = (x_on3_b && ab_b == 8'hC0) ? 4'bxxxx :
                 {ab_b[7] & ab_b[6], ab_b[5] & ab_b[4], ab_b[3] & ab_b[2], ab_b[1] & ab_b[0]};

    ls08_bist_ctrl dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a), .y(y_a),
        .ab(ab_a), .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_count(fc_a), .first_fail(ff_a), .vec_idx(vi_a), .state_dbg(st_a)
    );

    ls08_bist_ctrl #(.SETTLE_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b), .y(y_b),
        .ab(ab_b), .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_count(fc_b), .first_fail(ff_b), .vec_idx(vi_b), .state_dbg(st_b)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: build each vector from the gate/pair rules, AND the pairs,
    // apply stuck-at masks (stuck-1 dominates) and count differing vectors.
    function automatic void model_run(input logic [3:0] s0, input logic [3:0] s1,
                                      output int fc, output int ff);
        fc = 0;
        ff = 31;
        for (int i = 0; i < 18; i++) begin
            logic [7:0] stim;
            logic [3:0] good, seen;
            if (i < 16)       stim = 8'((i % 4) << (6 - 2 * (i / 4)));
            else if (i == 16) stim = 8'hFF;
            else              stim = 8'h00;
            for (int g = 0; g < 4; g++) good[3-g] = stim[7-2*g] & stim[6-2*g];
            seen = (good & ~s0) | s1;
            if (seen != good) begin
                fc++;
                if (ff == 31) ff = i;
            end
        end
    endfunction

    // Full run on instance a; caller is #1 after a rising edge.
    task automatic run_a(input logic [3:0] s0, input logic [3:0] s1, input string tag,
                         input int exp_fc, input int exp_ff, input int exp_pass);
        int n;
        s0_a    = s0;
        s1_a    = s1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        check($sformatf("%s busy_after_start", tag), busy_a, 1);
        n = 0;
        while (!done_a && n < 300) begin
            tick();
            n++;
        end
        check($sformatf("%s done_cycle", tag), n, 72);
        check($sformatf("%s fail_count", tag), fc_a, exp_fc);
        check($sformatf("%s first_fail", tag), ff_a, exp_ff);
        tick();
        check($sformatf("%s pass", tag), pass_a, exp_pass);
        check($sformatf("%s ab_after", tag), ab_a, 0);
        check($sformatf("%s busy_after", tag), busy_a, 0);
        check($sformatf("%s done_pulse_len", tag), done_a, 0);
    endtask

    typedef struct {
        logic [3:0] s0;
        logic [3:0] s1;
        int         fc;
        int         ff;
        int         ps;
    } vec_case_t;

    vec_case_t cases[6];

    initial begin
        int n, dones, efc, eff;
        logic [3:0] r0, r1;

        cases[0] = '{4'b0000, 4'b0000, 0, 31, 1};   // good gate
        cases[1] = '{4'b0100, 4'b0000, 2, 7, 0};    // y2 stuck 0: vectors 7, 16
        cases[2] = '{4'b0000, 4'b0001, 16, 0, 0};   // y4 stuck 1: all but 15, 16 expect y4=0
        cases[3] = '{4'b1000, 4'b0000, 2, 3, 0};    // y1 stuck 0: vectors 3, 16
        cases[4] = '{4'b0000, 4'b1111, 17, 0, 0};   // all stuck 1: all but 16
        cases[5] = '{4'b1111, 4'b0000, 5, 3, 0};    // all stuck 0: 3, 7, 11, 15, 16

        rst = 1'b1;
        start_a = 1'b0; abort_a = 1'b0; s0_a = '0; s1_a = '0;
        start_b = 1'b0; abort_b = 1'b0; x_on3_b = 1'b0;
        repeat (3) tick();
        check("reset ab", ab_a, 0);
        check("reset busy", busy_a, 0);
        check("reset done", done_a, 0);
        check("reset pass", pass_a, 0);
        check("reset fail_count", fc_a, 0);
        check("reset first_fail", ff_a, 31);
        check("reset vec_idx", vi_a, 0);
        check("reset state", st_a, 0);
        rst = 1'b0;
        tick();

        for (int k = 0; k < 6; k++)
            run_a(cases[k].s0, cases[k].s1, $sformatf("case%0d", k),
                  cases[k].fc, cases[k].ff, cases[k].ps);

        for (int k = 0; k < 8; k++) begin
            r0 = 4'($urandom_range(0, 15));
            r1 = 4'($urandom_range(0, 15));
            model_run(r0, r1, efc, eff);
            run_a(r0, r1, $sformatf("rand%0d s0=%0h s1=%0h", k, r0, r1), efc, eff, (efc == 0) ? 1 : 0);
        end

        // Abort at vector 5 with y4 stuck 1: vectors 0..4 already counted
        s0_a = '0;
        s1_a = 4'b0001;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (vi_a != 5'd5 && n < 200) begin
            tick();
            n++;
        end
        check("abort reached_vec5", vi_a, 5);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        check("abort busy", busy_a, 0);
        check("abort ab", ab_a, 0);
        check("abort pass", pass_a, 0);
        check("abort state", st_a, 0);
        check("abort fail_count_frozen", fc_a, 5);
        check("abort first_fail_frozen", ff_a, 0);
        dones = 0;
        for (int k = 0; k < 100; k++) begin
            if (done_a) dones++;
            tick();
        end
        check("abort no_done", dones, 0);
        run_a(4'b0000, 4'b0000, "after_abort", 0, 31, 1);

        // Zero settle, X on vector 3, stray start at cycle 10
        x_on3_b = 1'b1;
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 0;
        while (!done_b && n < 300) begin
            start_b = (n == 9);
            tick();
            n++;
        end
        start_b = 1'b0;
        check("settle0 done_cycle", n, 36);
        check("settle0 fail_count", fc_b, 1);
        check("settle0 first_fail", ff_b, 3);
        tick();
        check("settle0 pass", pass_b, 0);
        check("settle0 busy_after", busy_b, 0);
        x_on3_b = 1'b0;

        // Asynchronous reset at cycle 40 of a failing run
        s0_a = '0;
        s1_a = 4'b0001;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (39) tick();
        check("pre_rst busy", busy_a, 1);
        #3 rst = 1'b1;
        #1;
        check("rst ab", ab_a, 0);
        check("rst busy", busy_a, 0);
        check("rst done", done_a, 0);
        check("rst pass", pass_a, 0);
        check("rst fail_count", fc_a, 0);
        check("rst first_fail", ff_a, 31);
        check("rst vec_idx", vi_a, 0);
        check("rst state", st_a, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        dones = 0;
        for (int k = 0; k < 100; k++) begin
            if (done_a || done_b) dones++;
            tick();
        end
        check("rst no_done", dones, 0);
        check("rst idle_after", busy_a, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
